// File: rtl/disc_frame_loader.sv
// disc_frame_loader: streams a 3x3 frame into a_1..a_9, holds it SETTLE cycles, captures y_in.
// Optional framing check on s_last is enabled by defining DISC_LAST_CHECK_EN.
module disc_frame_loader #(
    parameter int WIDTH = 32,
    parameter int N_INPUT = 9,
    parameter int SETTLE = 2,
    parameter logic signed [WIDTH-1:0] THRESH = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] a_1,
    output logic [WIDTH-1:0] a_2,
    output logic [WIDTH-1:0] a_3,
    output logic [WIDTH-1:0] a_4,
    output logic [WIDTH-1:0] a_5,
    output logic [WIDTH-1:0] a_6,
    output logic [WIDTH-1:0] a_7,
    output logic [WIDTH-1:0] a_8,
    output logic [WIDTH-1:0] a_9,
    input  logic [WIDTH-1:0] y_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_score,
    output logic             m_real,
    output logic             frame_err
);
    localparam logic [3:0] LAST_IDX    = 4'(N_INPUT - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       idx;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] a_q [9];
    logic             accept;
    logic             last_idx;
    logic             short_frame;
    logic             write_en;
    logic             capture;

    // Both streams: a beat transfers on the rising edge where valid && ready.
    assign s_ready  = (state == ST_LOAD) && !rst;
    assign m_valid  = (state == ST_OUT);
    assign accept   = s_valid && s_ready;
    assign last_idx = (idx == LAST_IDX);

`ifdef DISC_LAST_CHECK_EN
    logic missing_last;
    logic frame_err_q;

    assign short_frame  = accept && s_last && !last_idx;
    assign missing_last = accept && !s_last && last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= short_frame || missing_last;
    end
    assign frame_err = frame_err_q;
`else
    logic unused_last;

    assign unused_last = s_last;
    assign short_frame = 1'b0;
    assign frame_err   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        write_en   = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_LOAD: begin
                if (accept) begin
                    write_en = !short_frame;
                    if (last_idx) state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) state_next = ST_LOAD;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 4'd0;
            cnt     <= 4'd0;
            m_score <= '0;
            m_real  <= 1'b0;
            for (int i = 0; i < 9; i++) a_q[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (write_en && idx == 4'(i)) a_q[i] <= s_data;
            end
            // A short frame restarts indexing without leaving LOAD.
            if (accept) begin
                if (last_idx || short_frame) idx <= 4'd0;
                else                         idx <= idx + 4'd1;
            end
            if (accept && last_idx)                 cnt <= SETTLE_INIT;
            else if (state == ST_SETTLE && cnt != 0) cnt <= cnt - 4'd1;
            if (capture) begin
                m_score <= y_in;
                m_real  <= ($signed(y_in) > THRESH);
            end
        end
    end

    assign a_1 = a_q[0];
    assign a_2 = a_q[1];
    assign a_3 = a_q[2];
    assign a_4 = a_q[3];
    assign a_5 = a_q[4];
    assign a_6 = a_q[5];
    assign a_7 = a_q[6];
    assign a_8 = a_q[7];
    assign a_9 = a_q[8];
endmodule

// File: tb/tb_disc_frame_loader.sv
// Scoreboard bench for disc_frame_loader: directed frames push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_disc_frame_loader;
    localparam int W = 32;
    localparam int SETTLE = 2;
    localparam int CW = 9 * W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         s_last = 1'b0;
    logic [W-1:0] a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9;
    logic [W-1:0] y_in;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_score;
    logic         m_real;
    logic         frame_err;

    // Discriminator stand-in: sum of the presented samples unless a value is forced.
    logic         y_force_en = 1'b0;
    logic [W-1:0] y_force = '0;
    assign y_in = y_force_en ? y_force : (a_1 + a_2 + a_3 + a_4 + a_5 + a_6 + a_7 + a_8 + a_9);

    logic [W-1:0]  fr [9];
    logic [W:0]    exp_q [$];
    logic [CW-1:0] exp_a_q [$];
    logic [W:0]    e;
    logic [CW-1:0] ea;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_accept_cyc = 0;
    int first_cyc = 0;
    int hs_cyc = 0;
    int acc_count = 0;
    int err_count = 0;
    int exp_err = 0;
    bit skip_acc_check = 1'b0;
    logic prev_valid = 1'b0;

    disc_frame_loader #(.WIDTH(W), .N_INPUT(9), .SETTLE(SETTLE), .THRESH('0)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .a_1(a_1), .a_2(a_2), .a_3(a_3), .a_4(a_4), .a_5(a_5),
        .a_6(a_6), .a_7(a_7), .a_8(a_8), .a_9(a_9),
        .y_in(y_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_score(m_score), .m_real(m_real),
        .frame_err(frame_err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] score, input logic rl);
        logic [CW-1:0] packed_fr;
        for (int i = 0; i < 9; i++) packed_fr[i*W +: W] = fr[i];
        exp_q.push_back({rl, score});
        exp_a_q.push_back(packed_fr);
    endtask

    task automatic send_sample(input logic [W-1:0] d, input logic last);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 200) begin
                check("s_ready_timeout", CW'(s_ready), CW'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        last_accept_cyc = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit last9);
        for (int i = 0; i < 9; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sample(fr[i], (i == 8) ? last9 : 1'b0);
            if (i == 0) first_cyc = last_accept_cyc;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", CW'(exp_q.size()), CW'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (!m_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            acc_count = 0;
        end else begin
            if (s_valid && s_ready) acc_count++;
            if (frame_err) err_count++;
            if (m_valid && !prev_valid) begin
                check("latency", CW'(cyc - last_accept_cyc), CW'(SETTLE));
                if (!skip_acc_check) check("accepts_per_frame", CW'(acc_count), CW'(9));
                acc_count = 0;
            end
            if (m_valid && m_ready) begin
                hs_cyc = cyc + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got score %0h, expected no result", m_score);
                end else begin
                    e  = exp_q.pop_front();
                    ea = exp_a_q.pop_front();
                    check("score", CW'(m_score), CW'(e[W-1:0]));
                    check("real", CW'(m_real), CW'(e[W]));
                    check("frame", {a_9, a_8, a_7, a_6, a_5, a_4, a_3, a_2, a_1}, ea);
                end
            end
        end
        prev_valid = m_valid;
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_s_ready", CW'(s_ready), CW'(0));
        check("rst_m_valid", CW'(m_valid), CW'(0));
        check("rst_a", {a_9, a_8, a_7, a_6, a_5, a_4, a_3, a_2, a_1}, CW'(0));
        check("rst_score", CW'(m_score), CW'(0));
        check("rst_real", CW'(m_real), CW'(0));
        check("rst_frame_err", CW'(frame_err), CW'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1..9 through the summing model
        fr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        push_exp(32'd45, 1'b1);
        send_frame(1'b0, 1'b1);
        drain();

        // Forced scores around the threshold
        y_force_en = 1'b1;
        y_force = 32'hFFFF_FFFD;
        push_exp(32'hFFFF_FFFD, 1'b0);
        send_frame(1'b0, 1'b1);
        drain();
        y_force = 32'd0;
        push_exp(32'd0, 1'b0);
        send_frame(1'b0, 1'b1);
        drain();
        y_force = 32'd1;
        push_exp(32'd1, 1'b1);
        send_frame(1'b0, 1'b1);
        drain();
        y_force = 32'h8000_0000;
        push_exp(32'h8000_0000, 1'b0);
        send_frame(1'b0, 1'b1);
        drain();
        y_force = 32'h7FFF_FFFF;
        push_exp(32'h7FFF_FFFF, 1'b1);
        send_frame(1'b0, 1'b1);
        drain();
        y_force_en = 1'b0;

        // Back-pressure: result held while the next frame waits
        m_ready = 1'b0;
        fr = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18};
        push_exp(32'd126, 1'b1);
        send_frame(1'b0, 1'b1);
        fr = '{9{32'hFFFF_FFFF}};
        push_exp(32'hFFFF_FFF7, 1'b0);
        fork
            send_frame(1'b0, 1'b1);
            begin
                wait_valid();
                check("hold_valid", CW'(m_valid), CW'(1));
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("hold_s_ready", CW'(s_ready), CW'(0));
                    check("hold_score", CW'(m_score), CW'(126));
                end
                @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        check("next_frame_start", CW'(first_cyc - hs_cyc), CW'(1));
        drain();

        // Random valid gaps over three frames
        fr = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        push_exp(32'd1, 1'b1);
        send_frame(1'b1, 1'b1);
        fr = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, -32'sd41};
        push_exp(32'hFFFF_FFFF, 1'b0);
        send_frame(1'b1, 1'b1);
        fr = '{9{32'd1000}};
        push_exp(32'd9000, 1'b1);
        send_frame(1'b1, 1'b1);
        drain();

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) send_sample(32'd7, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_s_ready", CW'(s_ready), CW'(0));
        check("midrst_a", {a_9, a_8, a_7, a_6, a_5, a_4, a_3, a_2, a_1}, CW'(0));
        check("midrst_m_valid", CW'(m_valid), CW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        fr = '{9{32'd3}};
        push_exp(32'd27, 1'b1);
        send_frame(1'b0, 1'b1);
        drain();

`ifdef DISC_LAST_CHECK_EN
        // Short frame: s_last on the 4th sample
        skip_acc_check = 1'b1;
        send_sample(32'd100, 1'b0);
        send_sample(32'd101, 1'b0);
        send_sample(32'd102, 1'b0);
        send_sample(32'd103, 1'b1);
        repeat (3) @(negedge clk);
        exp_err = exp_err + 1;
        check("short_frame_err", CW'(err_count), CW'(exp_err));
        fr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        push_exp(32'd45, 1'b1);
        send_frame(1'b0, 1'b1);
        drain();
        skip_acc_check = 1'b0;

        // Missing s_last on the 9th sample
        fr = '{9{32'd2}};
        push_exp(32'd18, 1'b1);
        send_frame(1'b0, 1'b0);
        drain();
        exp_err = exp_err + 1;
        check("missing_last_err", CW'(err_count), CW'(exp_err));
`endif

        check("frame_err_total", CW'(err_count), CW'(exp_err));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/disc_frame_loader.md
# disc_frame_loader

Sequential front-end and result-capture stage for the combinational `discriminator` MLP. It receives one 3x3 frame as nine signed WIDTH-bit samples over a valid/ready stream and holds them stable on `a_1`..`a_9`. It then waits a fixed settle interval for the discriminator's combinational path and registers the returned `y`. The block presents the score and a real/fake decision on an output valid/ready stream.

## Interface
Parameters:
- `WIDTH`, 32: sample, score and `y` width, signed two's complement.
- `N_INPUT`, 9: samples per frame. Fixed at 9; other values are unsupported.
- `SETTLE`, 2: cycles the loaded frame is held before `y` is captured. Legal range is 1..15.
- `THRESH`, 0: signed WIDTH-bit decision threshold.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  block accepts a sample this cycle.
- `s_data`  in  WIDTH  signed input sample.
- `s_last`  in  1  marks the final sample of a frame.
- `a_1`..`a_9`  out  WIDTH each  registered frame samples, wired to the discriminator inputs.
- `y_in`  in  WIDTH  discriminator output `y`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_score`  out  WIDTH  registered `y_in`.
- `m_real`  out  1  registered signed comparison `y_in > THRESH`.
- `frame_err`  out  1  one-cycle framing-error pulse (see Configuration).

## Operation
- States:
  - LOAD: `s_ready` = 1.
  - SETTLE: `s_ready` = 0; `a_*` frozen.
  - OUT: `s_ready` = 0; `m_valid` = 1.
- `s_ready` = (state == LOAD) and not `rst`. It is combinational from the state register.
- Sample index `idx` is 4 bits, 0..8.
- An accept is `s_valid` && `s_ready`. On an accept in LOAD, `s_data` is written into `a_(idx+1)`.
  - If `idx` < 8: `idx` increments.
  - If `idx` == 8: `idx` returns to 0, the settle counter loads SETTLE-1, and the state goes to SETTLE.
- `a_*` registers change only on an accept. Partially loaded frames therefore expose a mix of old and new samples. Consumers must use the result only when `m_valid` = 1.
- SETTLE behaviour:
  - If the counter != 0, it decrements.
  - If the counter == 0, the block captures `m_score` <= `y_in` and `m_real` <= (`$signed(y_in)` > `$signed(THRESH)`), then moves to OUT.
- OUT: `m_score` and `m_real` are held. On `m_valid` && `m_ready`, the state goes to LOAD.
- `m_valid` = (state == OUT). It is registered via the state encoding and has no combinational path from `m_ready`.
- No arithmetic is performed on samples. The comparison is a full-WIDTH signed compare, with no saturation or truncation.

## Timing
- Reset values:
  - state = LOAD, `idx` = 0, counter = 0.
  - `a_1`..`a_9` = 0, `m_score` = 0, `m_real` = 0.
  - `m_valid` = 0, `frame_err` = 0.
  - `s_ready` = 0 while `rst` is high.
- If `rst` is asserted mid-frame or mid-result, all state clears immediately, and the partial frame or pending result is discarded.
- Latency: the 9th sample is accepted at edge E0, and `y_in` is captured and `m_valid` rises at edge E0+SETTLE.
- Peak throughput: one sample per cycle in LOAD.
- Frame period: 9 + SETTLE + 1 cycles when `m_ready` is held at 1.
- Back-to-back: the OUT handshake at edge E returns the block to LOAD, and the first sample of the next frame can be accepted at edge E+1.
- `y_in` must be stable for SETTLE cycles after E0. This is guaranteed because `a_*` do not change outside LOAD.
- `s_valid` asserted in SETTLE or OUT is not accepted. The source must hold the sample until `s_ready` is 1.

## Configuration
- Macro `DISC_LAST_CHECK_EN`.
- Defined: `s_last` is checked on every accept.
  - `s_last` = 1 with `idx` < 8 (short frame): the sample is discarded, `idx` goes to 0, the state stays LOAD, and `frame_err` pulses for one cycle.
  - `s_last` = 0 with `idx` == 8: the frame is processed normally and `frame_err` pulses for one cycle.
- Undefined: `s_last` is ignored, `frame_err` is tied to 0, and frames are delimited purely by count.

## Test plan
- Reset then nine contiguous accepts of values 1..9, with `m_ready` = 1 and the bench model `y_in` = sum of `a_*`: `a_1`..`a_9` = 1..9, `m_valid` rises exactly SETTLE (2) edges after the 9th accept, `m_score` = 45, `m_real` = 1 (THRESH = 0).
- Same frame with `y_in` forced to -3: `m_score` = 0xFFFFFFFD, `m_real` = 0. With `y_in` = 0: `m_real` = 0, because the compare is strict.
- Hold `m_ready` = 0 for 5 cycles while `s_valid` stays 1: `s_ready` = 0 throughout, `m_score` is stable, no sample is lost, and the next frame loads starting the cycle after the handshake.
- Random `s_valid` gaps (valid on roughly 50% of cycles) over 3 frames: each result is correct, and exactly 9 accepts occur per frame.
- Assert `rst` after 5 accepts, then release and send a full frame: `a_*` are 0 after reset, and the first result reflects only the new frame.
- With `DISC_LAST_CHECK_EN` defined:
  - `s_last` = 1 on the 4th sample: `frame_err` pulses once and the next 9 samples form a valid frame.
  - `s_last` = 0 on the 9th sample: `frame_err` pulses and `m_valid` still rises.
